// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite response mux with registered data-phase select, default ERROR slave and error counter
module ahb_slave_mux #(
    parameter int NUM_SLAVES   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [NUM_SLAVES-1:0]            hsel,
    input  logic [1:0]                       htrans,
    input  logic [NUM_SLAVES-1:0]            hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            hresp_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    input  logic                             err_clr,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hready,
    output logic                             hresp,
    output logic [NUM_SLAVES-1:0]            dsel,
    output logic [ERRCNT_WIDTH-1:0]          err_cnt
);
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t             state;
    logic [NUM_SLAVES-1:0] first_sel;
    logic                  active;
    logic                  unmapped;

    assign active   = (htrans == 2'b10) || (htrans == 2'b11);
    assign unmapped = active && (hsel == '0);

    // Lowest-index select wins when the decoder drives more than one bit
    always_comb begin
        first_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (hsel[i]) begin
                first_sel    = '0;
                first_sel[i] = 1'b1;
            end
    end

    // Route the data-phase slave; the default slave's ERROR phases override the idle response
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (dsel[i]) begin
                hrdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                hready = hreadyout_s[i];
                hresp  = hresp_s[i];
            end
        if (state != DS_IDLE) begin
            hready = (state == DS_ERR2);
            hresp  = 1'b1;
        end
    end

    // Address-phase capture, default-slave sequencing and saturating error count
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel    <= '0;
            state   <= DS_IDLE;
            err_cnt <= '0;
        end else begin
            if (hready) begin
                dsel  <= active ? first_sel : '0;
                state <= unmapped ? DS_ERR1 : DS_IDLE;
            end else if (state == DS_ERR1) begin
                state <= DS_ERR2;
            end
            if (err_clr)
                err_cnt <= '0;
            else if (hready && hresp && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_slave_mux.sv
// tb_ahb_slave_mux: directed and random checks of ahb_slave_mux against a transfer-level model
module tb_ahb_slave_mux;
    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int DEF = NS;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic [NS-1:0]   hsel;
    logic [1:0]      htrans;
    logic [NS-1:0]   hreadyout_s;
    logic [NS-1:0]   hresp_s;
    logic [NS*DW-1:0] hrdata_s;
    logic            err_clr;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;
    logic [NS-1:0]   dsel;
    logic [7:0]      err_cnt;

    ahb_slave_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ERRCNT_WIDTH(8)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
        .err_clr(err_clr), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .dsel(dsel), .err_cnt(err_cnt)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int failures = 0;
    // Model: current data-phase target (-1 none, 0..NS-1 slave, DEF default slave), default phase, count
    int m_tgt = -1;
    int m_ph = 0;
    int m_cnt = 0;

    localparam logic [NS*DW-1:0] CAFE = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_rdy();
        if (m_tgt < 0) return 1'b1;
        if (m_tgt == DEF) return m_ph == 2;
        return hreadyout_s[m_tgt];
    endfunction

    function automatic logic exp_resp();
        if (m_tgt < 0) return 1'b0;
        if (m_tgt == DEF) return 1'b1;
        return hresp_s[m_tgt];
    endfunction

    function automatic logic [DW-1:0] exp_data();
        if (m_tgt < 0 || m_tgt == DEF) return '0;
        return hrdata_s[m_tgt*DW +: DW];
    endfunction

    function automatic logic [NS-1:0] exp_dsel();
        logic [NS-1:0] v;
        v = '0;
        if (m_tgt >= 0 && m_tgt < NS) v[m_tgt] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_tgt = -1;
        m_ph = 0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        logic r;
        logic e;
        int lo;
        r = exp_rdy();
        e = exp_resp();
        if (!hresetn) begin
            model_reset();
            return;
        end
        if (err_clr) m_cnt = 0;
        else if (r && e && m_cnt < 255) m_cnt++;
        if (r) begin
            if (htrans[1]) begin
                if (hsel == '0) begin
                    m_tgt = DEF;
                    m_ph = 1;
                end else begin
                    lo = -1;
                    for (int i = NS - 1; i >= 0; i--) if (hsel[i]) lo = i;
                    m_tgt = lo;
                end
            end else begin
                m_tgt = -1;
            end
        end else if (m_tgt == DEF && m_ph == 1) begin
            m_ph = 2;
        end
    endtask

    // Compare every output against the model, then advance one clock
    task automatic step();
        #1;
        chk("hready", hready, exp_rdy());
        chk("hresp", hresp, exp_resp());
        chk("hrdata", hrdata, exp_data());
        chk("dsel", dsel, exp_dsel());
        chk("err_cnt", err_cnt, m_cnt);
        @(posedge hclk);
        model_step();
        @(negedge hclk);
    endtask

    task automatic drive(input logic [1:0] t, input logic [NS-1:0] s);
        htrans = t;
        hsel = s;
    endtask

    initial begin
        hresetn = 1'b0;
        hsel = 4'b1011;
        htrans = 2'b10;
        hreadyout_s = 4'b0000;
        hresp_s = 4'b1111;
        hrdata_s = CAFE;
        err_clr = 1'b0;
        model_reset();
        @(negedge hclk);
        #1;
        chk("rst_hready", hready, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_dsel", dsel, 4'b0000);
        chk("rst_err_cnt", err_cnt, 8'd0);
        step();
        step();
        hresetn = 1'b1;
        hreadyout_s = 4'b1111;
        hresp_s = 4'b0000;
        drive(2'b10, 4'b0100);
        step();
        hreadyout_s = 4'b1011;
        drive(2'b11, 4'b0001);
        #1;
        chk("route_dsel_w1", dsel, 4'b0100);
        chk("route_hready_w1", hready, 1'b0);
        chk("route_hrdata_w1", hrdata, 32'hCAFE_0002);
        step();
        #1;
        chk("route_dsel_w2", dsel, 4'b0100);
        chk("route_hready_w2", hready, 1'b0);
        step();
        hreadyout_s = 4'b1111;
        #1;
        chk("route_hready_done", hready, 1'b1);
        chk("route_hrdata_done", hrdata, 32'hCAFE_0002);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("seq_dsel_switch", dsel, 4'b0001);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(2'b10, 4'b0000);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("def_err1_hready", hready, 1'b0);
        chk("def_err1_hresp", hresp, 1'b1);
        chk("def_err1_hrdata", hrdata, 32'h0);
        step();
        #1;
        chk("def_err2_hready", hready, 1'b1);
        chk("def_err2_hresp", hresp, 1'b1);
        step();
        #1;
        chk("def_err_cnt", err_cnt, 8'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(2'b10, 4'b0000);
        step();
        step();
        #1;
        chk("b2b_err2_hready", hready, 1'b1);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("b2b_err1_again", hready, 1'b0);
        chk("b2b_err1_hresp", hresp, 1'b1);
        step();
        #1;
        chk("b2b_err2_again", hready, 1'b1);
        step();
        #1;
        chk("b2b_err_cnt", err_cnt, 8'd2);
        chk("b2b_idle_hresp", hresp, 1'b0);
        drive(2'b01, 4'b0000);
        step();
        #1;
        chk("busy_hready", hready, 1'b1);
        chk("busy_hresp", hresp, 1'b0);
        chk("busy_err_cnt", err_cnt, 8'd2);
        drive(2'b10, 4'b0110);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("multihot_dsel", dsel, 4'b0010);
        chk("multihot_hrdata", hrdata, 32'hCAFE_0001);
        step();
        drive(2'b10, 4'b0001);
        hresp_s = 4'b0001;
        repeat (262) step();
        #1;
        chk("sat_err_cnt", err_cnt, 8'd255);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        hresp_s = 4'b0000;
        #1;
        chk("clr_priority", err_cnt, 8'd0);
        drive(2'b10, 4'b0000);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("mid_rst_err1", hready, 1'b0);
        hresetn = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_hready", hready, 1'b1);
        chk("mid_rst_hresp", hresp, 1'b0);
        chk("mid_rst_dsel", dsel, 4'b0000);
        step();
        hresetn = 1'b1;
        drive(2'b10, 4'b0001);
        step();
        drive(2'b00, 4'b0000);
        #1;
        chk("post_rst_dsel", dsel, 4'b0001);
        chk("post_rst_hresp", hresp, 1'b0);
        chk("post_rst_hrdata", hrdata, 32'hCAFE_0000);
        step();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            htrans = 2'($urandom);
            hsel = (r < 2) ? 4'b0000 : (r < 8) ? 4'(1 << $urandom_range(0, NS - 1)) : 4'($urandom);
            for (int i = 0; i < NS; i++) begin
                hreadyout_s[i] = ($urandom_range(0, 9) < 8);
                hresp_s[i] = ($urandom_range(0, 9) == 0);
            end
            hrdata_s = {$urandom, $urandom, $urandom, $urandom};
            err_clr = ($urandom_range(0, 99) < 3);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Parametrised AHB-Lite slave-to-master response multiplexer for NUM_SLAVES slaves. It registers the decoder select during the address phase and routes that slave's read data, ready and response back to the master during the data phase. It includes a built-in default slave that returns a two-cycle ERROR for transfers to unmapped space, plus a saturating error counter. It sits between the address decoder/slaves and the bus master, replacing the fixed two-slave RAM/ROM mux.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..16)
- DATA_WIDTH, 32, read-data width per slave
- ERRCNT_WIDTH, 8, width of saturating error counter
- hclk  input  1  bus clock, all state updates on rising edge
- hresetn  input  1  asynchronous active-low reset
- hsel  input  NUM_SLAVES  decoder select, address phase, expected one-hot or zero
- htrans  input  2  master transfer type, address phase (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- hreadyout_s  input  NUM_SLAVES  per-slave ready, bit i = slave i
- hresp_s  input  NUM_SLAVES  per-slave response (0 OKAY, 1 ERROR)
- hrdata_s  input  NUM_SLAVES*DATA_WIDTH  concatenated read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- err_clr  input  1  synchronous clear of err_cnt
- hrdata  output  DATA_WIDTH  muxed read data to master
- hready  output  1  muxed ready to master and all slaves
- hresp  output  1  muxed response to master
- dsel  output  NUM_SLAVES  registered data-phase select (debug/visibility)
- err_cnt  output  ERRCNT_WIDTH  count of completed ERROR responses, saturating

## Operation
- Address-phase capture happens on the rising edge only when hready=1. When hready=0, all captured state holds.
  - active = htrans[1] (NONSEQ or SEQ).
  - hsel multi-hot: the lowest set index wins; the other bits are ignored.
  - dsel <= active ? lowest-set-bit(hsel) : 0.
  - Unmapped access (active and hsel==0) arms the default slave.
- Data-phase routing when dsel bit i is set:
  - hrdata = slice i of hrdata_s
  - hready = hreadyout_s[i]
  - hresp = hresp_s[i]
- No slave selected and default slave idle: hrdata=0, hready=1, hresp=0 (zero-wait OKAY). This covers IDLE/BUSY transfers and reset.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 on a capture edge with an unmapped access. Otherwise stays in DS_IDLE.
  - DS_ERR1 outputs hready=0, hresp=1, hrdata=0. It always moves to DS_ERR2 on the next edge.
  - DS_ERR2 outputs hready=1, hresp=1, hrdata=0. This is a capture edge:
    - next state is DS_ERR1 if a new unmapped access is sampled;
    - otherwise DS_IDLE, with dsel loaded from hsel as normal.
  - dsel is 0 throughout DS_ERR1/DS_ERR2.
- err_cnt:
  - Increments by 1 on each edge where hready=1 and hresp=1, i.e. the final cycle of any ERROR from a slave or from the default slave.
  - Saturates at 2^ERRCNT_WIDTH-1.
  - err_clr=1 clears it to 0 and takes priority over a simultaneous increment.
- Slave-generated ERROR is passed through unmodified. The mux does not enforce the two-cycle protocol on real slaves.

## Timing
- Reset values (asynchronous, immediate on hresetn=0): dsel=0, FSM=DS_IDLE, err_cnt=0. Outputs are therefore hready=1, hresp=0, hrdata=0.
- Reset asserted mid-transfer, including during DS_ERR1, aborts the transfer. Outputs take their reset values the same cycle, with no wait for a clock.
- Latency:
  - The select is registered: the address phase at edge N routes slave data from cycle N+1 onward.
  - The data path from hrdata_s/hreadyout_s/hresp_s to the outputs is purely combinational (zero cycles).
- Wait states: while the selected slave holds hreadyout_s[i]=0, dsel holds. The next address phase is captured on the first edge with hready=1.
- Back-to-back transfers to different slaves: dsel switches on the edge that completes the previous data phase.
- Default ERROR is exactly 2 data-phase cycles. Back-to-back unmapped accesses give ERR1,ERR2,ERR1,ERR2 with no idle cycle between them.

## Test plan
- Reset: hold hresetn=0 with arbitrary inputs -> hready=1, hresp=0, hrdata=0, dsel=0, err_cnt=0. Deassert, then drive NONSEQ hsel=0100 -> dsel=0100 one cycle later.
- Routing: NONSEQ to slave 2 with hrdata_s slice 2=32'hCAFE_0002 and slave 2 inserting 2 wait states -> hrdata=CAFE_0002, hready low for 2 cycles then high, dsel stable throughout. A following SEQ to slave 0 switches dsel to 0001 only after hready=1.
- Default slave: NONSEQ with hsel=0 -> next cycle hready=0/hresp=1, following cycle hready=1/hresp=1, err_cnt=1. Two back-to-back unmapped NONSEQs -> ERR1,ERR2,ERR1,ERR2 and err_cnt=2.
- IDLE/BUSY with hsel=0 -> hready=1, hresp=0, no FSM change, err_cnt unchanged. Multi-hot hsel=0110 with NONSEQ -> dsel=0010, slave 1 routed.
- err_cnt: with ERRCNT_WIDTH=8, force 260 slave ERROR completions -> err_cnt=255. Assert err_clr on the same cycle as an ERROR completion -> err_cnt=0.
- Reset mid-operation: assert hresetn=0 during DS_ERR1 -> hready=1 and hresp=0 immediately. After release, FSM is DS_IDLE and an OKAY transfer completes normally.
